// File: rtl/zbus_pkg.sv
// Shared definitions for the Z80 bus-cycle generator: request encodings,
// half-T state enumeration and bus widths.
package zbus_pkg;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int RW = 7;

  typedef enum logic [2:0] {
    RT_OPFETCH = 3'b000,
    RT_MEMRD   = 3'b001,
    RT_MEMWR   = 3'b010,
    RT_IORD    = 3'b011,
    RT_IOWR    = 3'b100
  } req_type_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T1H,
    ST_T1L,
    ST_T2H,
    ST_T2L,
    ST_TWH,
    ST_TWL,
    ST_T3H,
    ST_T3L,
    ST_T4H,
    ST_T4L
  } zstate_e;

  function automatic logic type_valid(input logic [2:0] t);
    return (t <= RT_IOWR);
  endfunction

endpackage

// File: rtl/zbus_tstate_seq.sv
// Half-T state sequencer: walks T1..T4 on the Z80 clock edge enables,
// inserting wait states from WAIT or the I/O auto-wait.
module zbus_tstate_seq
  import zbus_pkg::*;
#(
  parameter bit IO_AUTOWAIT = 1'b1,
  parameter bit WAIT_EN     = 1'b1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    zpos,
  input  logic    zneg,
  input  logic    req,
  input  logic    req_ok,
  input  logic    cur_opfetch,
  input  logic    cur_io,
  input  logic    wait_n,
  output zstate_e state_o,
  output zstate_e state_d_o,
  output logic    take_o,
  output logic    end_o
);

  zstate_e state_q, state_d;
  logic    end_q;
  logic    final_l, take, start, wait_ok;

  always_comb begin
    final_l = ((state_q == ST_T3L) && !cur_opfetch) || (state_q == ST_T4L);
    take    = zpos && req && ((state_q == ST_IDLE) || final_l);
    start   = take && req_ok;
    wait_ok = !WAIT_EN || wait_n;
    state_d = state_q;
    // zpos takes priority; a coincident zneg is dropped.
    if (zpos) begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_T1H;
        ST_T1L:  state_d = ST_T2H;
        ST_T2L:  state_d = ((cur_io && IO_AUTOWAIT) || !wait_ok) ? ST_TWH : ST_T3H;
        ST_TWL:  state_d = wait_ok ? ST_T3H : ST_TWH;
        ST_T3L:  state_d = cur_opfetch ? ST_T4H : (start ? ST_T1H : ST_IDLE);
        ST_T4L:  state_d = start ? ST_T1H : ST_IDLE;
        default: ;
      endcase
    end else if (zneg) begin
      case (state_q)
        ST_T1H:  state_d = ST_T1L;
        ST_T2H:  state_d = ST_T2L;
        ST_TWH:  state_d = ST_TWL;
        ST_T3H:  state_d = ST_T3L;
        ST_T4H:  state_d = ST_T4L;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      end_q   <= zpos && final_l;
    end
  end

  assign state_o   = state_q;
  assign state_d_o = state_d;
  assign take_o    = take;
  assign end_o     = end_q;

endmodule

// File: rtl/zbus_master.sv
// Z80 bus-cycle generator: turns single transfer requests into Z80-timed
// strobes, address and data. All bus outputs are registered from next state.
module zbus_master
  import zbus_pkg::*;
#(
  parameter bit IO_AUTOWAIT = 1'b1,
  parameter bit WAIT_EN     = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          zpos,
  input  logic          zneg,
  input  logic          req,
  input  logic [2:0]    req_type,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [7:0]    i_reg,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  input  logic [DW-1:0] din,
  input  logic          wait_n,
  output logic [AW-1:0] a,
  output logic [DW-1:0] dout,
  output logic          dout_oe,
  output logic          m1_n,
  output logic          mreq_n,
  output logic          iorq_n,
  output logic          rd_n,
  output logic          wr_n,
  output logic          rfsh_n
);

  zstate_e       state_q, state_d;
  logic          take, req_ok;
  logic [2:0]    type_q, cur_type;
  logic [AW-1:0] addr_q, cur_addr, a_q, a_d;
  logic [DW-1:0] wdata_q, cur_wdata, dout_q, dout_d, rdata_q;
  logic [RW-1:0] r_q;
  logic          busy_q, err_q, oe_q, oe_d;
  logic          m1_q, mreq_q, iorq_q, rd_q, wr_q, rfsh_q;
  logic          m1_d, mreq_d, iorq_d, rd_d, wr_d, rfsh_d;
  logic          is_of, is_mr, is_mw, is_ir, is_iw;
  logic          early, pre3, iowin, refr, cap_rd;

  assign req_ok = type_valid(req_type);

  zbus_tstate_seq #(
    .IO_AUTOWAIT (IO_AUTOWAIT),
    .WAIT_EN     (WAIT_EN)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .zpos        (zpos),
    .zneg        (zneg),
    .req         (req),
    .req_ok      (req_ok),
    .cur_opfetch (type_q == RT_OPFETCH),
    .cur_io      ((type_q == RT_IORD) || (type_q == RT_IOWR)),
    .wait_n      (wait_n),
    .state_o     (state_q),
    .state_d_o   (state_d),
    .take_o      (take),
    .end_o       (done)
  );

  // Decode against the request that will own the next state, so a freshly
  // accepted request drives the bus from its very first half-state.
  always_comb begin
    cur_type  = take ? req_type  : type_q;
    cur_addr  = take ? req_addr  : addr_q;
    cur_wdata = take ? req_wdata : wdata_q;
    is_of = (cur_type == RT_OPFETCH);
    is_mr = (cur_type == RT_MEMRD);
    is_mw = (cur_type == RT_MEMWR);
    is_ir = (cur_type == RT_IORD);
    is_iw = (cur_type == RT_IOWR);
    early = state_d inside {ST_T1H, ST_T1L, ST_T2H, ST_T2L, ST_TWH, ST_TWL};
    pre3  = state_d inside {ST_T1L, ST_T2H, ST_T2L, ST_TWH, ST_TWL};
    iowin = state_d inside {ST_T2H, ST_T2L, ST_TWH, ST_TWL, ST_T3H};
    refr  = is_of && (state_d inside {ST_T3H, ST_T3L, ST_T4H, ST_T4L});

    m1_d   = !(is_of && early);
    mreq_d = !(((is_of || is_mr || is_mw) && pre3) ||
               ((is_mr || is_mw) && (state_d == ST_T3H)) ||
               (is_of && (state_d inside {ST_T3L, ST_T4H})));
    rd_d   = !(((is_of || is_mr) && pre3) ||
               (is_mr && (state_d == ST_T3H)) ||
               (is_ir && iowin));
    wr_d   = !((is_mw && (state_d inside {ST_T2L, ST_TWH, ST_TWL, ST_T3H})) ||
               (is_iw && iowin));
    iorq_d = !((is_ir || is_iw) && iowin);
    rfsh_d = !refr;
    oe_d   = (is_mw || is_iw) &&
             (state_d inside {ST_T1L, ST_T2H, ST_T2L, ST_TWH, ST_TWL, ST_T3H, ST_T3L});
    dout_d = oe_d ? cur_wdata : dout_q;

    a_d = a_q;
    if (refr)                    a_d = {i_reg, 1'b0, r_q};
    else if (state_d != ST_IDLE) a_d = cur_addr;

    // Opcode is taken on entry to T3H; memory/I/O reads on entry to T3L.
    cap_rd = ((type_q == RT_OPFETCH) && (state_q != ST_T3H) && (state_d == ST_T3H)) ||
             (((type_q == RT_MEMRD) || (type_q == RT_IORD)) &&
              (state_q == ST_T3H) && (state_d == ST_T3L));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      a_q     <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      rdata_q <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      m1_q    <= 1'b1;
      mreq_q  <= 1'b1;
      iorq_q  <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      rfsh_q  <= 1'b1;
    end else begin
      if (take) begin
        type_q  <= req_type;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      err_q  <= take && !req_ok;
      busy_q <= (state_d != ST_IDLE);
      a_q    <= a_d;
      dout_q <= dout_d;
      oe_q   <= oe_d;
      m1_q   <= m1_d;
      mreq_q <= mreq_d;
      iorq_q <= iorq_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      rfsh_q <= rfsh_d;
      if (cap_rd) rdata_q <= din;
      if ((state_q == ST_T4L) && (state_d != ST_T4L)) r_q <= r_q + 7'd1;
    end
  end

  assign busy    = busy_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign a       = a_q;
  assign dout    = dout_q;
  assign dout_oe = oe_q;
  assign m1_n    = m1_q;
  assign mreq_n  = mreq_q;
  assign iorq_n  = iorq_q;
  assign rd_n    = rd_q;
  assign wr_n    = wr_q;
  assign rfsh_n  = rfsh_q;

  ap_zclk_excl: assert property (@(posedge clk) disable iff (!rst_n) !(zpos && zneg));
  ap_m1_iorq:   assert property (@(posedge clk) disable iff (!rst_n) !(!m1_n && !iorq_n));
  ap_rd_wr:     assert property (@(posedge clk) disable iff (!rst_n) !(!rd_n && !wr_n));

endmodule
